// File: rtl/r5p_bus_pkg.sv
// Shared types for the r5p unified memory bus arbiter.
package r5p_bus_pkg;

  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_LCK_IF = 2'd1, ARB_LCK_LS = 2'd2} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} arb_own_t;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/r5p_arb_cnt.sv
// Saturating starvation counter for the fetch port; sat is high once STARVE
// consecutive denied fetch cycles have been seen.
module r5p_arb_cnt
  import r5p_bus_pkg::*;
#(
  parameter int unsigned STARVE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic sat
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE);

  logic [CNT_W-1:0] cnt_r;

  // Count denied fetch cycles, holding at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != LIMIT)) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == LIMIT);

endmodule

// File: rtl/r5p_bus_arb.sv
// Fetch vs load/store arbiter onto one single-port memory bus, with read-data routing.
// Optional fetch promotion after STARVE denied cycles: define R5P_BUS_ARB_STARVE_EN.
module r5p_bus_arb
  import r5p_bus_pkg::*;
#(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned BW     = DW/8,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_adr,
  output logic [DW-1:0] if_rdt,
  output logic          if_ack,
  input  logic          ls_req,
  input  logic          ls_wen,
  input  logic [AW-1:0] ls_adr,
  input  logic [BW-1:0] ls_ben,
  input  logic [DW-1:0] ls_wdt,
  output logic [DW-1:0] ls_rdt,
  output logic          ls_ack,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_adr,
  output logic [BW-1:0] mem_ben,
  output logic [DW-1:0] mem_wdt,
  input  logic [DW-1:0] mem_rdt,
  input  logic          mem_ack
);

  if ((STARVE < 32'd1) || (STARVE > 32'd15)) begin : g_starve_range
    $error("r5p_bus_arb: STARVE must be within 1..15");
  end

  arb_state_t state_r, state_nxt_s;
  arb_own_t   grant_s, own_r, own_nxt_s;
  logic       promote_s;

`ifdef R5P_BUS_ARB_STARVE_EN
  logic sat_s;

  r5p_arb_cnt #(.STARVE(STARVE)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (if_ack | ~if_req),
    .inc (if_req & ~if_ack),
    .sat (sat_s)
  );

  assign promote_s = sat_s && (state_r == ARB_IDLE);
`else
  assign promote_s = 1'b0;
`endif

  // Grant selection and lock tracking; reset forces no grant so the bus is quiet.
  always_comb begin
    grant_s     = OWN_NONE;
    state_nxt_s = state_r;
    if (rst) begin
      grant_s     = OWN_NONE;
      state_nxt_s = ARB_IDLE;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (ls_req && !promote_s) begin
            grant_s = OWN_LS;
          end else if (if_req) begin
            grant_s = OWN_IF;
          end else begin
            grant_s = OWN_NONE;
          end
          if ((grant_s == OWN_IF) && !mem_ack) begin
            state_nxt_s = ARB_LCK_IF;
          end else if ((grant_s == OWN_LS) && !mem_ack) begin
            state_nxt_s = ARB_LCK_LS;
          end else begin
            state_nxt_s = ARB_IDLE;
          end
        end
        ARB_LCK_IF: begin
          grant_s     = OWN_IF;
          state_nxt_s = mem_ack ? ARB_IDLE : ARB_LCK_IF;
        end
        ARB_LCK_LS: begin
          grant_s     = OWN_LS;
          state_nxt_s = mem_ack ? ARB_IDLE : ARB_LCK_LS;
        end
        default: begin
          grant_s     = OWN_NONE;
          state_nxt_s = ARB_IDLE;
        end
      endcase
    end
  end

  // Memory-side mux; fetches are always full-width reads.
  always_comb begin
    mem_req = 1'b0;
    mem_wen = 1'b0;
    mem_adr = ls_adr;
    mem_ben = ls_ben;
    mem_wdt = ls_wdt;
    case (grant_s)
      OWN_IF: begin
        mem_req = if_req;
        mem_wen = 1'b0;
        mem_adr = if_adr;
        mem_ben = {BW{1'b1}};
      end
      OWN_LS: begin
        mem_req = ls_req;
        mem_wen = ls_wen;
        mem_adr = ls_adr;
        mem_ben = ls_ben;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign if_ack = mem_ack && (grant_s == OWN_IF);
  assign ls_ack = mem_ack && (grant_s == OWN_LS);

  // Only acked reads produce a response next cycle.
  always_comb begin
    own_nxt_s = OWN_NONE;
    if (mem_ack && (grant_s != OWN_NONE) && !mem_wen) begin
      own_nxt_s = grant_s;
    end else begin
      own_nxt_s = OWN_NONE;
    end
  end

  // Arbiter state and response owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
      own_r   <= OWN_NONE;
    end else begin
      state_r <= state_nxt_s;
      own_r   <= own_nxt_s;
    end
  end

  assign if_rdt = ((own_r == OWN_IF) && !rst) ? mem_rdt : {DW{1'b0}};
  assign ls_rdt = ((own_r == OWN_LS) && !rst) ? mem_rdt : {DW{1'b0}};

endmodule
